letter_tx_queue: RTL
====================

LETTER_TX_QUEUE -- requirements
Module: letter_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 32, queue capacity in letters; power of two, at least 4.
REQ-002 SHALL have parameter GAP_CYCLES, default 1000, idle clk_in cycles enforced between consecutive letters; 0 means no gap.
REQ-003 SHALL have port clk_in  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_in  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port data_valid_in  input  1  single-cycle push strobe from the enigma stage.
REQ-006 SHALL have port data_in  input  5  letter code, 0..25 = A..Z.
REQ-007 SHALL have port flush_in  input  1  discard all queued letters.
REQ-008 SHALL have port tx_busy_in  input  1  busy flag from the IR transmitter.
REQ-009 SHALL have port tx_valid_out  output  1  one-cycle letter-issue strobe to the IR transmitter.
REQ-010 SHALL have port tx_data_out  output  5  letter being issued, held stable from issue until tx_busy_in falls.
REQ-011 SHALL have port count_out  output  clog2(DEPTH)+1  number of stored letters.
REQ-012 SHALL have port full_out  output  1  high when count_out equals DEPTH.
REQ-013 SHALL have port empty_out  output  1  high when count_out equals 0.
REQ-014 SHALL have port drop_count_out  output  16  dropped-push counter.

Function
REQ-015 SHALL accept a push when data_valid_in=1, data_in<=25, flush_in=0, and the queue is not full (or a pop occurs in the same cycle); written at wr_ptr, wr_ptr wraps modulo DEPTH.
REQ-016 SHALL silently discard pushes with data_in in 26..31; these are not counted as drops.
REQ-017 SHALL treat a push while full with no same-cycle pop as a drop: data lost, drop counter incremented.
REQ-018 SHALL run a transmit FSM with states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
REQ-019 IDLE->ISSUE when the queue is non-empty and tx_busy_in=0; tx_data_out loads the head letter on this transition.
REQ-020 In ISSUE, SHALL drive tx_valid_out=1 for exactly one cycle, then go to WAIT_BUSY.
REQ-021 In WAIT_BUSY, SHALL wait indefinitely for tx_busy_in=1; on that cycle SHALL pop the head (rd_ptr advance, count decrement) and go to WAIT_DONE.
REQ-022 In WAIT_DONE, SHALL go to GAP when tx_busy_in=0, or to IDLE if GAP_CYCLES=0.
REQ-023 In GAP, SHALL count GAP_CYCLES cycles, then go to IDLE.
REQ-024 Letter latency, push into an empty idle queue to tx_valid_out: SHALL be exactly 2 cycles.
REQ-025 Simultaneous push and pop SHALL leave count_out unchanged.
REQ-026 flush_in SHALL take effect in one cycle: pointers equal, count 0, and a same-cycle push ignored.
REQ-027 flush_in in ISSUE or WAIT_BUSY SHALL return the FSM to IDLE with no pop; in WAIT_DONE or GAP the FSM SHALL continue normally.
REQ-028 count_out, full_out and empty_out SHALL be registered and consistent in the same cycle.

Reset
REQ-029 On rst_in=1, SHALL asynchronously force: FSM=IDLE, pointers=0, count_out=0, empty_out=1, full_out=0, tx_valid_out=0, tx_data_out=0, drop_count_out=0, gap counter=0.
REQ-030 Reset mid-transmission SHALL abandon the in-flight letter; no re-issue after release.
REQ-031 Storage contents SHALL NOT be reset.

Configuration
REQ-032 With macro LETTER_TXQ_DROP_COUNT_EN defined, drop_count_out SHALL increment by 1 per drop, saturating at 0xFFFF, cleared only by reset.
REQ-033 Without LETTER_TXQ_DROP_COUNT_EN, drop_count_out SHALL be constant 0 and no counter logic SHALL be synthesised; drop behaviour is otherwise unchanged.

Verification
REQ-034 Push 3 into idle queue, tx_busy_in=0 -> tx_valid_out high 2 cycles later with tx_data_out=3, count_out=1 until busy rises.
REQ-035 Push 7,1,25 back-to-back with a model transmitter (busy 50 cycles), GAP_CYCLES=10 -> letters issued in order 7,1,25; consecutive tx_valid_out pulses at least 50+10 cycles apart; empty_out=1 at end.
REQ-036 Fill DEPTH=4 with 0,1,2,3 while busy held high, push 9 -> full_out=1, 9 dropped, drop_count_out=1 (0 without macro); push 30 -> no drop count change.
REQ-037 Full queue, push on the pop cycle (busy rising) -> push accepted, count_out stays 4, new letter later issued last.
REQ-038 Flush asserted in WAIT_BUSY with 3 queued -> FSM to IDLE, count_out=0, no pop; later push 5 issues 5.
REQ-039 Assert rst_in during WAIT_DONE -> all outputs at reset values immediately (asynchronously); no tx_valid_out after release until a new push.

Source files
------------

// File: rtl/letter_tx_queue_if.sv
// letter_tx_queue_if: push side, transmitter handshake and status bundle for letter_tx_queue
interface letter_tx_queue_if #(parameter int DEPTH = 32);
  logic                    data_valid_in;
  logic [4:0]              data_in;
  logic                    flush_in;
  logic                    tx_busy_in;
  logic                    tx_valid_out;
  logic [4:0]              tx_data_out;
  logic [$clog2(DEPTH):0]  count_out;
  logic                    full_out;
  logic                    empty_out;
  logic [15:0]             drop_count_out;
  modport slave (
    input  data_valid_in, data_in, flush_in, tx_busy_in,
    output tx_valid_out, tx_data_out, count_out, full_out, empty_out, drop_count_out
  );
  modport master (
    output data_valid_in, data_in, flush_in, tx_busy_in,
    input  tx_valid_out, tx_data_out, count_out, full_out, empty_out, drop_count_out
  );
endinterface

// File: rtl/letter_tx_queue.sv
// letter_tx_queue: letter FIFO feeding an IR transmitter with inter-letter gap; drop counter enabled by LETTER_TXQ_DROP_COUNT_EN
module letter_tx_queue #(
  parameter int DEPTH      = 32,
  parameter int GAP_CYCLES = 1000
) (
  input logic             clk_in,
  input logic             rst_in,
  letter_tx_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 2);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t          state, nxt;
  logic [4:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_nxt;
  logic [GW-1:0]   gap_cnt;
  logic            legal, push, pop;

  assign legal     = q.data_valid_in && q.data_in <= 5'd25 && !q.flush_in;
  assign pop       = state == WAIT_BUSY && q.tx_busy_in && !q.flush_in;
  assign push      = legal && (!q.full_out || pop);
  assign count_nxt = q.flush_in ? '0 : q.count_out + CW'(push) - CW'(pop);
  assign q.tx_valid_out = state == ISSUE;

  // letter storage, deliberately left out of reset
  always_ff @(posedge clk_in)
    if (push) mem[wr_ptr] <= q.data_in;

  // pointers and registered occupancy flags, all derived from the same next count
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q.count_out <= '0;
      q.full_out  <= 1'b0;
      q.empty_out <= 1'b1;
    end else begin
      wr_ptr      <= q.flush_in ? '0 : wr_ptr + AW'(push);
      rd_ptr      <= q.flush_in ? '0 : rd_ptr + AW'(pop);
      q.count_out <= count_nxt;
      q.full_out  <= count_nxt == CW'(DEPTH);
      q.empty_out <= count_nxt == '0;
    end

  // transmit FSM state, gap timer and issued-letter latch
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state         <= IDLE;
      gap_cnt       <= '0;
      q.tx_data_out <= '0;
    end else begin
      state   <= nxt;
      gap_cnt <= state == GAP ? gap_cnt + GW'(1) : '0;
      if (state == IDLE && nxt == ISSUE) q.tx_data_out <= mem[rd_ptr];
    end

  // transmit FSM next state; a flush before the pop abandons the letter
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = (!q.empty_out && !q.tx_busy_in && !q.flush_in) ? ISSUE : IDLE;
      ISSUE:     nxt = q.flush_in ? IDLE : WAIT_BUSY;
      WAIT_BUSY: nxt = q.flush_in ? IDLE : q.tx_busy_in ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE: nxt = q.tx_busy_in ? WAIT_DONE : (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:       nxt = (gap_cnt == GW'(GAP_CYCLES - 1)) ? IDLE : GAP;
      default:   nxt = IDLE;
    endcase
  end

`ifdef LETTER_TXQ_DROP_COUNT_EN
  logic drop;
  assign drop = legal && q.full_out && !pop;

  // saturating count of legal pushes lost to a full queue
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) q.drop_count_out <= '0;
    else if (drop && q.drop_count_out != 16'hFFFF) q.drop_count_out <= q.drop_count_out + 16'd1;
`else
  assign q.drop_count_out = '0;
`endif
endmodule
